// File: rtl/rvv_fifo_2w_packer_pkg.sv
// Shared types and helpers for the 2-write FIFO packer.
// Optional statistics counters are enabled with RVV_PACKER_STATS_EN.
package rvv_packer_pkg;

  localparam int DEFAULT_LANES = 4;

  typedef logic [DEFAULT_LANES-1:0] lane_mask_t;
  typedef logic [1:0]               credit_t;

  // Write slots the FIFO can absorb this cycle.
  function automatic credit_t credits_from_status(input logic full, input logic one_left);
    if (full)          return credit_t'(0);
    else if (one_left) return credit_t'(1);
    else               return credit_t'(2);
  endfunction

endpackage

// File: rtl/rvv_fifo_2w_packer_if.sv
// Bundle-in / FIFO-push bus between the upstream producer, the packer and the 2-write FIFO.
interface rvv_fifo_2w_packer_if #(
  parameter int DWIDTH = 32,
  parameter int LANES  = 4
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES-1:0]         in_mask;
  logic [LANES*DWIDTH-1:0]  in_data;
  logic                     push0;
  logic [DWIDTH-1:0]        inData0;
  logic                     push1;
  logic [DWIDTH-1:0]        inData1;
  logic                     fifo_full;
  logic                     fifo_1left_to_full;
  logic                     busy;

  modport slave (
    input  flush, in_valid, in_mask, in_data, fifo_full, fifo_1left_to_full,
    output in_ready, push0, inData0, push1, inData1, busy
  );

  modport master (
    output flush, in_valid, in_mask, in_data, fifo_full, fifo_1left_to_full,
    input  in_ready, push0, inData0, push1, inData1, busy
  );
endinterface

// File: rtl/rvv_fifo_2w_packer_ff2_sel.sv
// Combinational find-first-two: lowest and second-lowest set bits of a lane mask.
module rvv_ff2_sel #(
  parameter int LANES = 4,
  parameter int IDXW  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0] mask,
  output logic             found0,
  output logic [IDXW-1:0]  idx0,
  output logic             found1,
  output logic [IDXW-1:0]  idx1
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    found0 = 1'b0;
    idx0   = '0;
    found1 = 1'b0;
    idx1   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        if (!found0) begin
          found0 = 1'b1;
          idx0   = IDXW'(i);
        end else if (!found1) begin
          found1 = 1'b1;
          idx1   = IDXW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/rvv_fifo_2w_packer.sv
// Holds one sparse lane bundle and drains active lanes, two per cycle, into a 2-write FIFO.
// Define RVV_PACKER_STATS_EN to add push and stall counters.
module rvv_fifo_2w_packer
  import rvv_packer_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int LANES  = DEFAULT_LANES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rvv_fifo_2w_packer_if.slave  bus
`ifdef RVV_PACKER_STATS_EN
  ,
  output logic [31:0]          stat_push_cnt,
  output logic [31:0]          stat_stall_cnt
`endif
);

  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0]        hold_mask_q, hold_mask_d, mask_nxt;
  logic [LANES*DWIDTH-1:0] hold_data_q, hold_data_d;
  credit_t                 credits;
  logic                    found0, found1;
  logic [IDXW-1:0]         idx0, idx1;
  logic                    push0, push1, load, busy;

  assign credits = credits_from_status(bus.fifo_full, bus.fifo_1left_to_full);

  rvv_ff2_sel #(.LANES(LANES), .IDXW(IDXW)) u_sel (
    .mask   (hold_mask_q),
    .found0 (found0),
    .idx0   (idx0),
    .found1 (found1),
    .idx1   (idx1)
  );

  // push1 depends on found1, which implies found0, so it never fires alone.
  always_comb begin
    push0    = found0 && (credits != credit_t'(0));
    push1    = found1 && (credits == credit_t'(2));
    mask_nxt = hold_mask_q;
    if (push0) mask_nxt[idx0] = 1'b0;
    if (push1) mask_nxt[idx1] = 1'b0;
  end

  assign busy         = |hold_mask_q;
  assign bus.in_ready = (mask_nxt == '0) && !bus.flush;
  assign load         = bus.in_valid && bus.in_ready;

  assign bus.push0   = push0;
  assign bus.push1   = push1;
  assign bus.inData0 = push0 ? hold_data_q[int'(idx0)*DWIDTH +: DWIDTH] : '0;
  assign bus.inData1 = push1 ? hold_data_q[int'(idx1)*DWIDTH +: DWIDTH] : '0;
  assign bus.busy    = busy;

  // Inactive lanes keep their old data; only the mask decides what gets pushed.
  always_comb begin
    hold_mask_d = mask_nxt;
    hold_data_d = hold_data_q;
    if (bus.flush) begin
      hold_mask_d = '0;
    end else if (load) begin
      hold_mask_d = bus.in_mask;
      for (int i = 0; i < LANES; i++) begin
        if (bus.in_mask[i]) hold_data_d[i*DWIDTH +: DWIDTH] = bus.in_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_mask_q <= '0;
      hold_data_q <= '0;
    end else begin
      hold_mask_q <= hold_mask_d;
      hold_data_q <= hold_data_d;
    end
  end

`ifdef RVV_PACKER_STATS_EN
  logic [31:0] push_cnt_q, push_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    push_cnt_d  = push_cnt_q + 32'(push0) + 32'(push1);
    stall_cnt_d = stall_cnt_q + 32'(busy && (credits == credit_t'(0)));
    if (bus.flush) begin
      push_cnt_d  = '0;
      stall_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      push_cnt_q  <= push_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_push_cnt  = push_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rvv_fifo_2w_packer.sv
// Self-checking bench: queue-based lane model compared every cycle, plus directed literal checks.
module tb_rvv_fifo_2w_packer;
  import rvv_packer_pkg::*;

  localparam int DW = 32;
  localparam int LN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rvv_fifo_2w_packer_if #(.DWIDTH(DW), .LANES(LN)) bus ();

`ifdef RVV_PACKER_STATS_EN
  logic [31:0] stat_push_cnt, stat_stall_cnt;
`endif

  rvv_fifo_2w_packer #(.DWIDTH(DW), .LANES(LN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RVV_PACKER_STATS_EN
    ,
    .stat_push_cnt  (stat_push_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the held bundle is just an ordered queue of pending lane values.
  logic [DW-1:0] pend[$];
  logic [31:0]   m_push_cnt = 0;
  logic [31:0]   m_stall_cnt = 0;

  initial begin
    forever begin
      int unsigned credit, n;
      logic          e_busy, e_ready;
      logic [DW-1:0] e_d0, e_d1;
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
        m_push_cnt  = 0;
        m_stall_cnt = 0;
      end
      credit  = bus.fifo_full ? 0 : (bus.fifo_1left_to_full ? 1 : 2);
      n       = (credit < pend.size()) ? credit : pend.size();
      e_busy  = pend.size() != 0;
      e_d0    = (n >= 1) ? pend[0] : '0;
      e_d1    = (n >= 2) ? pend[1] : '0;
      e_ready = (pend.size() == n) && !bus.flush;
      check("busy",     32'(bus.busy),     32'(e_busy));
      check("in_ready", 32'(bus.in_ready), 32'(e_ready));
      check("push0",    32'(bus.push0),    32'(n >= 1));
      check("push1",    32'(bus.push1),    32'(n >= 2));
      check("inData0",  bus.inData0,       e_d0);
      check("inData1",  bus.inData1,       e_d1);
`ifdef RVV_PACKER_STATS_EN
      check("stat_push_cnt",  stat_push_cnt,  m_push_cnt);
      check("stat_stall_cnt", stat_stall_cnt, m_stall_cnt);
`endif
      if (rst_n) begin
        if (bus.flush) begin
          m_push_cnt  = 0;
          m_stall_cnt = 0;
        end else begin
          m_push_cnt  = m_push_cnt + n;
          m_stall_cnt = m_stall_cnt + 32'(e_busy && credit == 0);
        end
        repeat (n) void'(pend.pop_front());
        if (bus.flush) begin
          pend.delete();
        end else if (bus.in_valid && e_ready) begin
          for (int i = 0; i < LN; i++)
            if (bus.in_mask[i]) pend.push_back(bus.in_data[i*DW +: DW]);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input lane_mask_t m, input logic [DW-1:0] base);
    bus.in_valid = 1'b1;
    bus.in_mask  = m;
    for (int i = 0; i < LN; i++) bus.in_data[i*DW +: DW] = base + DW'(i);
  endtask

  initial begin
    bus.flush              = 1'b0;
    bus.in_valid           = 1'b0;
    bus.in_mask            = '0;
    bus.in_data            = '0;
    bus.fifo_full          = 1'b0;
    bus.fifo_1left_to_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    repeat (5) begin
      @(negedge clk);
      check("idle in_ready", 32'(bus.in_ready), 32'd1);
      check("idle push0",    32'(bus.push0),    32'd0);
      check("idle busy",     32'(bus.busy),     32'd0);
    end

    // Full drain, then a back-to-back bundle that stalls for 3 cycles
    next_cycle();
    set_bundle(4'b1111, 32'hD000_0000);
    @(negedge clk); check("drain accept", 32'(bus.in_ready), 32'd1);
    next_cycle();
    set_bundle(4'b0111, 32'hE000_0000);
    @(negedge clk);
    check("drain c1 d0", bus.inData0, 32'hD000_0000);
    check("drain c1 d1", bus.inData1, 32'hD000_0001);
    check("drain c1 ready", 32'(bus.in_ready), 32'd0);
    next_cycle();
    @(negedge clk);
    check("drain c2 d0", bus.inData0, 32'hD000_0002);
    check("drain c2 d1", bus.inData1, 32'hD000_0003);
    check("drain c2 ready", 32'(bus.in_ready), 32'd1);
    next_cycle();
    bus.in_valid  = 1'b0;
    bus.fifo_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall push0", 32'(bus.push0), 32'd0);
      check("stall ready", 32'(bus.in_ready), 32'd0);
      check("stall busy",  32'(bus.busy), 32'd1);
      next_cycle();
    end
    bus.fifo_full = 1'b0;
    @(negedge clk);
    check("release d0", bus.inData0, 32'hE000_0000);
    check("release d1", bus.inData1, 32'hE000_0001);
    next_cycle();
    @(negedge clk);
    check("release2 d0", bus.inData0, 32'hE000_0002);
    check("release2 p1", 32'(bus.push1), 32'd0);
    next_cycle();
    @(negedge clk);
    check("drained busy", 32'(bus.busy), 32'd0);
`ifdef RVV_PACKER_STATS_EN
    check("stats push",  stat_push_cnt,  32'd7);
    check("stats stall", stat_stall_cnt, 32'd3);
`endif

    // Sparse mask with a single FIFO slot
    next_cycle();
    set_bundle(4'b1010, 32'hF000_0000);
    bus.fifo_1left_to_full = 1'b1;
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("sparse p0", 32'(bus.push0), 32'd1);
    check("sparse d0", bus.inData0, 32'hF000_0001);
    check("sparse p1", 32'(bus.push1), 32'd0);
    next_cycle();
    bus.fifo_1left_to_full = 1'b0;
    @(negedge clk);
    check("sparse2 d0", bus.inData0, 32'hF000_0003);
    check("sparse2 p1", 32'(bus.push1), 32'd0);

    // Zero mask is consumed silently
    next_cycle();
    set_bundle(4'b0000, 32'hA000_0000);
    @(negedge clk); check("zero accept", 32'(bus.in_ready), 32'd1);
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("zero busy", 32'(bus.busy), 32'd0);
    check("zero push", 32'(bus.push0), 32'd0);

    // Flush a bundle held under a full FIFO
    next_cycle();
    set_bundle(4'b1111, 32'hB000_0000);
    bus.fifo_full = 1'b1;
    next_cycle();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    @(negedge clk);
    check("flush ready", 32'(bus.in_ready), 32'd0);
    check("flush busy",  32'(bus.busy), 32'd1);
    next_cycle();
    bus.flush     = 1'b0;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    check("post flush busy", 32'(bus.busy), 32'd0);
    check("post flush push", 32'(bus.push0), 32'd0);

    // Randomized traffic with one asynchronous reset mid-stream
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_mask  = LN'($urandom);
      for (int i = 0; i < LN; i++) bus.in_data[i*DW +: DW] = $urandom;
      bus.fifo_full          = ($urandom_range(0, 3) == 0);
      bus.fifo_1left_to_full = ($urandom_range(0, 3) == 0);
      bus.flush              = ($urandom_range(0, 19) == 0);
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    end
    next_cycle();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
